// File: rtl/eth_pkg.sv
// Shared constants and FSM state type for the Clause-22 MDIO master.
package eth_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam logic [5:0] PREAMBLE_BITS = 6'd32;
  localparam logic [5:0] TA_START      = 6'd46;
  localparam logic [5:0] TA_ERR_BIT    = 6'd47;
  localparam logic [5:0] DATA_START    = 6'd48;
  localparam int         FRAME_BITS    = 64;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_RST_WAIT,
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } mdio_state_t;

endpackage

// File: rtl/mdio_tick_gen.sv
// MDC generator: half-period counter that runs only while enabled and
// emits single-cycle strobes on the clk cycle before each MDC edge.
module mdio_tick_gen #(
  parameter int CLK_DIV = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_rise_tick,
  output logic o_fall_tick,
  output logic o_mdc
);

  localparam int                DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_mdc;
  logic             w_half_end;

  assign w_half_end  = i_en && (r_div == DIV_LAST);
  assign o_rise_tick = w_half_end && !r_mdc;
  assign o_fall_tick = w_half_end && r_mdc;
  assign o_mdc       = r_mdc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
      r_mdc <= 1'b0;
    end else if (!i_en) begin
      r_div <= '0;
      r_mdc <= 1'b0;
    end else if (w_half_end) begin
      r_div <= '0;
      r_mdc <= !r_mdc;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master with PHY hardware-reset sequencer; serialises one
// 64-bit read/write frame per accepted command.
module mdio_master
  import eth_pkg::*;
#(
  parameter int CLK_DIV         = 20,
  parameter int PHY_RST_CYCLES  = 1000,
  parameter int PHY_WAIT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        phy_rstn,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int SEQ_MAX = (PHY_RST_CYCLES > PHY_WAIT_CYCLES) ? PHY_RST_CYCLES : PHY_WAIT_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam logic [SEQ_W-1:0] RST_LAST  = SEQ_W'(PHY_RST_CYCLES - 1);
  localparam logic [SEQ_W-1:0] WAIT_LAST = SEQ_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [5:0]       LAST_BIT  = 6'(FRAME_BITS - 1);

  mdio_state_t      r_state, w_next;
  logic [SEQ_W-1:0] r_seq;
  logic             r_phy_rstn;
  logic             r_write;
  logic [31:0]      r_tx;
  logic [5:0]       r_bit;
  logic             r_mdio_o, r_mdio_oe;
  logic [15:0]      r_rx;
  logic             r_err;
  logic             r_rsp_valid;
  logic [15:0]      r_rsp_rdata;
  logic             r_rsp_err;

  logic       w_accept, w_rise, w_fall;
  logic [5:0] w_bit_nx;
  logic       w_oe_nx, w_o_nx;

  mdio_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk         (clk),
    .rst         (rst),
    .i_en        (r_state == ST_SHIFT),
    .o_rise_tick (w_rise),
    .o_fall_tick (w_fall),
    .o_mdc       (mdc)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

  // Bits past the preamble come from the latched 32-bit header/data word.
  assign w_bit_nx = r_bit + 1'b1;
  assign w_oe_nx  = r_write || (w_bit_nx < TA_START);
  assign w_o_nx   = !w_oe_nx || (w_bit_nx < PREAMBLE_BITS) || r_tx[~w_bit_nx[4:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RST_HOLD;
    else      r_state <= w_next;
  end

  // NOTE: next state defaults to the current state first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_RST_HOLD: if (r_seq == RST_LAST)  w_next = ST_RST_WAIT;
      ST_RST_WAIT: if (r_seq == WAIT_LAST) w_next = ST_IDLE;
      ST_IDLE:     if (w_accept)           w_next = ST_SHIFT;
      ST_SHIFT:    if (w_fall && (r_bit == LAST_BIT)) w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_RST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seq       <= '0;
      r_phy_rstn  <= 1'b0;
      r_write     <= 1'b0;
      r_tx        <= '0;
      r_bit       <= '0;
      r_mdio_o    <= 1'b1;
      r_mdio_oe   <= 1'b0;
      r_rx        <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;

      if (w_next != r_state)
        r_seq <= '0;
      else if (r_state == ST_RST_HOLD || r_state == ST_RST_WAIT)
        r_seq <= r_seq + 1'b1;

      if (w_next == ST_RST_WAIT) r_phy_rstn <= 1'b1;

      if (w_accept) begin
        r_write   <= cmd_write;
        r_tx      <= {MDIO_ST, cmd_write ? MDIO_OP_WR : MDIO_OP_RD,
                      cmd_phy, cmd_reg, MDIO_TA_WR, cmd_wdata};
        r_bit     <= '0;
        r_mdio_o  <= 1'b1;
        r_mdio_oe <= 1'b1;
      end else if (r_state == ST_SHIFT) begin
        if (w_rise && !r_write) begin
          if (r_bit == TA_ERR_BIT)  r_err <= mdio_i;
          if (r_bit >= DATA_START) r_rx  <= {r_rx[14:0], mdio_i};
        end
        if (w_fall) begin
          if (r_bit == LAST_BIT) begin
            r_mdio_o    <= 1'b1;
            r_mdio_oe   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_write ? 16'h0000 : r_rx;
            r_rsp_err   <= r_write ? 1'b0 : r_err;
          end else begin
            r_bit     <= w_bit_nx;
            r_mdio_oe <= w_oe_nx;
            r_mdio_o  <= w_o_nx;
          end
        end
      end
    end
  end

  assign phy_rstn  = r_phy_rstn;
  assign mdio_o    = r_mdio_o;
  assign mdio_oe   = r_mdio_oe;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
